// File: rtl/pcs_link_controller.sv
// 1000BASE-X PCS receive link sequencer: debounces signal_detect, gates the sync FSM,
// times out stalled acquisition with a backoff, and qualifies sync before raising link_up.
module pcs_link_controller #(
  parameter int unsigned DEBOUNCE_CYC = 16,
  parameter int unsigned ACQ_TIMEOUT  = 1024,
  parameter int unsigned HOLDOFF_CYC  = 64,
  parameter int unsigned BACKOFF_CYC  = 32,
  parameter int unsigned CNT_W        = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             enable_i,
  input  logic             signal_detect_i,
  input  logic             sync_status_i,
  input  logic             clear_counters_i,
  output logic             sync_enable_o,
  output logic             sync_restart_o,
  output logic             link_up_o,
  output logic             rx_enable_o,
  output logic [CNT_W-1:0] loss_count_o,
  output logic [CNT_W-1:0] acq_fail_count_o,
  output logic [5:0]       state_out_o
);

  localparam int unsigned MaxAB  = (DEBOUNCE_CYC > ACQ_TIMEOUT) ? DEBOUNCE_CYC : ACQ_TIMEOUT;
  localparam int unsigned MaxCD  = (HOLDOFF_CYC > BACKOFF_CYC) ? HOLDOFF_CYC : BACKOFF_CYC;
  localparam int unsigned MaxCyc = (MaxAB > MaxCD) ? MaxAB : MaxCD;
  localparam int unsigned TimerW = $clog2(MaxCyc + 1);

  typedef logic [TimerW-1:0] timer_t;

  // Timer holds the count of qualifying cycles already seen, so expiry compares against N-1.
  localparam timer_t DebLast  = timer_t'(DEBOUNCE_CYC - 1);
  localparam timer_t AcqLast  = timer_t'(ACQ_TIMEOUT - 1);
  localparam timer_t HoldLast = timer_t'(HOLDOFF_CYC - 1);
  localparam timer_t BackLast = timer_t'(BACKOFF_CYC - 1);

  typedef enum logic [2:0] {
    StDisabled = 3'd0,
    StDebounce = 3'd1,
    StAcquire  = 3'd2,
    StHoldoff  = 3'd3,
    StLinkUp   = 3'd4,
    StBackoff  = 3'd5
  } state_e;

  state_e           state_q, state_d;
  timer_t           timer_q, timer_d;
  logic             sd_q;
  logic             restart_q, restart_d;
  logic [CNT_W-1:0] loss_q, loss_d;
  logic [CNT_W-1:0] fail_q, fail_d;
  logic             loss_inc, fail_inc;
  logic             sd_change;

  assign sd_change = signal_detect_i ^ sd_q;

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    restart_d = 1'b0;
    loss_inc  = 1'b0;
    fail_inc  = 1'b0;
    if (!enable_i) begin
      state_d  = StDisabled;
      timer_d  = '0;
      loss_inc = (state_q == StLinkUp);
    end else begin
      unique case (state_q)
        StDisabled: begin
          state_d = StDebounce;
          timer_d = '0;
        end
        StDebounce: begin
          if (signal_detect_i && !sd_change) begin
            if (timer_q == DebLast) begin
              state_d = StAcquire;
              timer_d = '0;
            end else begin
              timer_d = timer_q + timer_t'(1);
            end
          end else begin
            timer_d = '0;
          end
        end
        StAcquire: begin
          if (!signal_detect_i) begin
            state_d = StDebounce;
            timer_d = '0;
          end else if (sync_status_i) begin
            state_d = StHoldoff;
            timer_d = '0;
          end else if (timer_q == AcqLast) begin
            state_d   = StBackoff;
            timer_d   = '0;
            restart_d = 1'b1;
            fail_inc  = 1'b1;
          end else begin
            timer_d = timer_q + timer_t'(1);
          end
        end
        StHoldoff: begin
          if (!signal_detect_i) begin
            state_d = StDebounce;
            timer_d = '0;
          end else if (!sync_status_i) begin
            state_d = StAcquire;
            timer_d = '0;
          end else if (timer_q == HoldLast) begin
            state_d = StLinkUp;
            timer_d = '0;
          end else begin
            timer_d = timer_q + timer_t'(1);
          end
        end
        StLinkUp: begin
          timer_d = '0;
          if (!signal_detect_i) begin
            state_d  = StDebounce;
            loss_inc = 1'b1;
          end else if (!sync_status_i) begin
            state_d  = StAcquire;
            loss_inc = 1'b1;
          end
        end
        StBackoff: begin
          if (timer_q == BackLast) begin
            state_d = StDebounce;
            timer_d = '0;
          end else begin
            timer_d = timer_q + timer_t'(1);
          end
        end
        default: begin
          state_d = StDisabled;
          timer_d = '0;
        end
      endcase
    end
  end

  // Statistics saturate; a clear overrides any coincident increment.
  always_comb begin
    loss_d = loss_q;
    fail_d = fail_q;
    if (clear_counters_i) begin
      loss_d = '0;
      fail_d = '0;
    end else begin
      if (loss_inc && (loss_q != '1)) loss_d = loss_q + 1'b1;
      if (fail_inc && (fail_q != '1)) fail_d = fail_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= StDisabled;
      timer_q   <= '0;
      sd_q      <= 1'b0;
      restart_q <= 1'b0;
      loss_q    <= '0;
      fail_q    <= '0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      sd_q      <= signal_detect_i;
      restart_q <= restart_d;
      loss_q    <= loss_d;
      fail_q    <= fail_d;
    end
  end

  assign state_out_o      = 6'd1 << state_q;
  assign sync_enable_o    = (state_q == StAcquire) || (state_q == StHoldoff) ||
                            (state_q == StLinkUp);
  assign link_up_o        = (state_q == StLinkUp);
  assign rx_enable_o      = (state_q == StLinkUp);
  assign sync_restart_o   = restart_q;
  assign loss_count_o     = loss_q;
  assign acq_fail_count_o = fail_q;

endmodule

// File: tb/tb_pcs_link_controller.sv
// Directed bench for pcs_link_controller: bring-up, debounce glitch, timeout/backoff,
// link loss, enable override, counter saturation and clear priority.
module tb_pcs_link_controller;

  localparam logic [5:0] SDis  = 6'b000001;
  localparam logic [5:0] SDeb  = 6'b000010;
  localparam logic [5:0] SAcq  = 6'b000100;
  localparam logic [5:0] SHold = 6'b001000;
  localparam logic [5:0] SLink = 6'b010000;
  localparam logic [5:0] SBack = 6'b100000;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic       sd;
  logic       sync;
  logic       clr;
  logic       sync_enable;
  logic       sync_restart;
  logic       link_up;
  logic       rx_enable;
  logic [7:0] loss_count;
  logic [7:0] acq_fail_count;
  logic [5:0] state_out;

  int passed = 0;
  int total  = 0;

  pcs_link_controller dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .enable_i         (enable),
    .signal_detect_i  (sd),
    .sync_status_i    (sync),
    .clear_counters_i (clr),
    .sync_enable_o    (sync_enable),
    .sync_restart_o   (sync_restart),
    .link_up_o        (link_up),
    .rx_enable_o      (rx_enable),
    .loss_count_o     (loss_count),
    .acq_fail_count_o (acq_fail_count),
    .state_out_o      (state_out)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // State plus the state-derived outputs; rx_enable must track link_up.
  task automatic check_out(input string tag, input logic [5:0] st, input logic se,
                           input logic rs, input logic lu);
    check({tag, ".state"}, 32'(state_out), 32'(st));
    check({tag, ".sync_enable"}, 32'(sync_enable), 32'(se));
    check({tag, ".sync_restart"}, 32'(sync_restart), 32'(rs));
    check({tag, ".link_up"}, 32'(link_up), 32'(lu));
    check({tag, ".rx_enable"}, 32'(rx_enable), 32'(lu));
  endtask

  initial begin
    rst_n  = 1'b0;
    enable = 1'b1;
    sd     = 1'b1;
    sync   = 1'b1;
    clr    = 1'b0;

    tick(1);
    check_out("rst1", SDis, 1'b0, 1'b0, 1'b0);
    tick(1);
    check_out("rst2", SDis, 1'b0, 1'b0, 1'b0);
    check("rst2.loss", 32'(loss_count), 32'd0);
    check("rst2.fail", 32'(acq_fail_count), 32'd0);

    // Clean bring-up, edge k is the first edge with reset released.
    rst_n = 1'b1;
    tick(1);
    check_out("k", SDeb, 1'b0, 1'b0, 1'b0);
    tick(15);
    check_out("k+15", SDeb, 1'b0, 1'b0, 1'b0);
    tick(1);
    check_out("k+16", SAcq, 1'b1, 1'b0, 1'b0);
    tick(1);
    check_out("k+17", SHold, 1'b1, 1'b0, 1'b0);
    tick(63);
    check_out("k+80", SHold, 1'b1, 1'b0, 1'b0);
    tick(1);
    check_out("k+81", SLink, 1'b1, 1'b0, 1'b1);

    // Link loss by a one-cycle sync drop, then a drop during hold-off.
    sync = 1'b0;
    tick(1);
    check_out("loss1", SAcq, 1'b1, 1'b0, 1'b0);
    check("loss1.count", 32'(loss_count), 32'd1);
    sync = 1'b1;
    tick(1);
    check_out("reacq", SHold, 1'b1, 1'b0, 1'b0);
    sync = 1'b0;
    tick(1);
    check_out("hold_drop", SAcq, 1'b1, 1'b0, 1'b0);
    check("hold_drop.count", 32'(loss_count), 32'd1);
    sync = 1'b1;
    tick(1);
    tick(64);
    check_out("relink", SLink, 1'b1, 1'b0, 1'b1);

    // Leaving LINK_UP on signal_detect loss counts, then a debounce glitch.
    sd = 1'b0;
    tick(1);
    check_out("sd_drop", SDeb, 1'b0, 1'b0, 1'b0);
    check("sd_drop.count", 32'(loss_count), 32'd2);
    sd = 1'b1;
    tick(1);
    tick(10);
    sd = 1'b0;
    tick(1);
    sd = 1'b1;
    tick(1);
    tick(6);
    check_out("glitch+6", SDeb, 1'b0, 1'b0, 1'b0);
    tick(9);
    check_out("glitch+15", SDeb, 1'b0, 1'b0, 1'b0);
    tick(1);
    check_out("glitch+16", SAcq, 1'b1, 1'b0, 1'b0);

    // Acquisition timeout and backoff; signal_detect wobble in backoff is ignored.
    sync = 1'b0;
    tick(1023);
    check_out("acq1023", SAcq, 1'b1, 1'b0, 1'b0);
    check("acq1023.fail", 32'(acq_fail_count), 32'd0);
    tick(1);
    check_out("timeout1", SBack, 1'b0, 1'b1, 1'b0);
    check("timeout1.fail", 32'(acq_fail_count), 32'd1);
    tick(1);
    check_out("back+1", SBack, 1'b0, 1'b0, 1'b0);
    sd = 1'b0;
    tick(5);
    check_out("back+6", SBack, 1'b0, 1'b0, 1'b0);
    sd = 1'b1;
    tick(25);
    check_out("back+31", SBack, 1'b0, 1'b0, 1'b0);
    tick(1);
    check_out("back+32", SDeb, 1'b0, 1'b0, 1'b0);
    tick(16);
    check_out("retry_acq", SAcq, 1'b1, 1'b0, 1'b0);
    tick(1024);
    check_out("timeout2", SBack, 1'b0, 1'b1, 1'b0);
    check("timeout2.fail", 32'(acq_fail_count), 32'd2);

    // enable low on the timeout edge wins: DISABLED, no pulse, no count.
    tick(32);
    tick(16);
    check_out("retry2_acq", SAcq, 1'b1, 1'b0, 1'b0);
    tick(1023);
    enable = 1'b0;
    tick(1);
    check_out("dis_on_to", SDis, 1'b0, 1'b0, 1'b0);
    check("dis_on_to.fail", 32'(acq_fail_count), 32'd2);
    enable = 1'b1;
    sync   = 1'b1;
    tick(1);
    check_out("reenable", SDeb, 1'b0, 1'b0, 1'b0);
    tick(16 + 1 + 64);
    check_out("link3", SLink, 1'b1, 1'b0, 1'b1);

    // 256 more losses saturate loss_count at 255.
    for (int i = 0; i < 256; i++) begin
      sync = 1'b0;
      tick(1);
      sync = 1'b1;
      tick(1 + 64);
    end
    check_out("sat", SLink, 1'b1, 1'b0, 1'b1);
    check("sat.loss", 32'(loss_count), 32'd255);
    check("sat.fail", 32'(acq_fail_count), 32'd2);

    clr = 1'b1;
    tick(1);
    check("clr.loss", 32'(loss_count), 32'd0);
    check("clr.fail", 32'(acq_fail_count), 32'd0);

    // Clear coincident with a loss increment leaves zero.
    sync = 1'b0;
    tick(1);
    check_out("clr_inc", SAcq, 1'b1, 1'b0, 1'b0);
    check("clr_inc.loss", 32'(loss_count), 32'd0);
    clr  = 1'b0;
    sync = 1'b1;
    tick(1 + 64);
    sync = 1'b0;
    tick(1);
    check("post_clr.loss", 32'(loss_count), 32'd1);
    sync = 1'b1;
    tick(1 + 64);
    check_out("link4", SLink, 1'b1, 1'b0, 1'b1);

    // enable low out of LINK_UP also counts as a loss.
    enable = 1'b0;
    tick(1);
    check_out("dis_link", SDis, 1'b0, 1'b0, 1'b0);
    check("dis_link.loss", 32'(loss_count), 32'd2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pcs_link_controller.md
Name: pcs_link_controller

Overview:
Sequences the 1000BASE-X PCS receive synchronization process. The block debounces signal_detect and enables the sync state machine. If sync is not acquired in time, it restarts the sync machine with a backoff. It qualifies sync_status with a hold-off before asserting link_up/rx_enable to the receive state machine. It sits between the PMA signal_detect/sync FSM and the PCS receive path, and keeps saturating loss/failure statistics.

Parameters:
DEBOUNCE_CYC, 16, consecutive cycles signal_detect must be 1 and unchanged before acquisition starts
ACQ_TIMEOUT, 1024, cycles allowed in ACQUIRE for sync_status to rise
HOLDOFF_CYC, 64, consecutive cycles sync_status must stay OK before link_up
BACKOFF_CYC, 32, cycles sync_enable is held low after an acquisition timeout
CNT_W, 8, width of the statistics counters

Ports:
clk  input  1  single rising-edge clock
reset  input  1  synchronous, active-low reset
enable  input  1  management enable; 0 forces DISABLED
signal_detect  input  1  PMA signal detect
sync_status  input  1  from sync FSM; OK=1, FAIL=0
clear_counters  input  1  synchronous clear of statistics counters
sync_enable  output  1  1 lets the sync FSM run; 0 holds it in LOSS_OF_SYNC
sync_restart  output  1  one-cycle pulse forcing the sync FSM to LOSS_OF_SYNC
link_up  output  1  qualified link indication
rx_enable  output  1  enables the PCS receive FSM; equals link_up
loss_count  output  CNT_W  saturating count of LINK_UP->not-LINK_UP drops
acq_fail_count  output  CNT_W  saturating count of acquisition timeouts
state_out  output  6  one-hot current state, bit order DISABLED,DEBOUNCE,ACQUIRE,HOLDOFF,LINK_UP,BACKOFF (bit0..5)

Behaviour:
- All outputs are registered (Moore). Reset is synchronous and active-low: reset==0 at a posedge gives state DISABLED, all outputs 0, all counters/timers 0, and state_out=6'b000001.
- sync_enable=1 in ACQUIRE, HOLDOFF and LINK_UP; 0 elsewhere. link_up=rx_enable=1 only in LINK_UP.
- Transition priority in every state:
  1. enable==0 -> DISABLED.
  2. signal_detect==0 while in ACQUIRE/HOLDOFF/LINK_UP -> DEBOUNCE.
  3. sync_status events.
  4. timer expiry.
- sd_change = signal_detect differs from its value sampled on the previous cycle. Its register resets to 0.
- DISABLED: on enable==1 -> DEBOUNCE, with the debounce counter cleared.
- DEBOUNCE: the counter increments on each cycle with signal_detect==1 and !sd_change, and clears otherwise. On the DEBOUNCE_CYC-th consecutive good sample -> ACQUIRE, with the acquisition timer cleared.
- ACQUIRE: sync_status==1 -> HOLDOFF with the hold-off counter cleared. Otherwise the timer increments. On the ACQ_TIMEOUT-th cycle without sync -> BACKOFF; sync_restart=1 for exactly that next cycle, and acq_fail_count increments.
- HOLDOFF: sync_status==0 -> ACQUIRE with the timer cleared; no loss is counted. On the HOLDOFF_CYC-th consecutive sampled sync_status==1 -> LINK_UP.
- LINK_UP: sync_status==0 -> ACQUIRE, loss_count increments, and link_up is 0 from the next cycle. Leaving LINK_UP via signal_detect==0 or enable==0 also increments loss_count.
- BACKOFF: sync_enable=0 for BACKOFF_CYC cycles, then -> DEBOUNCE with the counter cleared. signal_detect is ignored during BACKOFF.
- Counters saturate at 2^CNT_W-1; they never wrap.
- clear_counters==1 zeroes both statistics counters next cycle. If it coincides with an increment, the clear wins.
- sync_restart is never asserted outside the cycle following a timeout. enable==0 in that same cycle still yields DISABLED, and no pulse is produced.
- Timers are sized to hold their max parameter value; they are cleared on every state entry.

Test Plan:
- Reset low 2 cycles while enable=1 and signal_detect=1 -> all outputs 0 and state_out=000001 throughout; DEBOUNCE is entered on the first edge with reset=1.
- Clean bring-up: enable=1 at edge k, signal_detect=1 and sync_status=1 steady. Required sequence:
  - ACQUIRE at edge k+16 (sync_enable=1).
  - HOLDOFF at edge k+17.
  - LINK_UP at edge k+81 (link_up=rx_enable=1).
- Debounce glitch: signal_detect drops for 1 cycle after 10 good samples -> the counter restarts; ACQUIRE is reached 16 good samples after the glitch ends, not 6.
- Timeout: sync_status=0 held -> after 1024 ACQUIRE cycles, sync_restart pulses for exactly 1 cycle, acq_fail_count=1, and sync_enable=0 for 32 cycles. Then DEBOUNCE, and the cycle repeats (count=2 on the next timeout).
- Link loss: in LINK_UP drop sync_status for 1 cycle -> link_up=0 next cycle, loss_count=1, state ACQUIRE. A sync_status drop during HOLDOFF leaves loss_count unchanged.
- Saturation/clear: force 256 losses with CNT_W=8 -> loss_count stays 255. Assert clear_counters on the same cycle as an increment -> 0.
